// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers four BCD digits from a scanned,
// active-low common-anode 7-segment bus.
// Ports:
//   clk, rst_n    - system clock, async active-low reset
//   segment7[6:0] - scanned segments, gfedcba, active-low
//   an[3:0]       - digit enables, active-low one-hot (an[0]=D .. an[3]=A)
//   bcd_out[15:0] - last complete frame {A,B,C,D}
//   frame_valid   - one-cycle pulse when bcd_out updates
//   frame_bad     - level, frame held an undecodable digit
//   seg_err       - pulse on accepted undecodable pattern
//   an_err        - pulse on accepted illegal an value
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  segment7,
    input  logic [3:0]  an,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        frame_bad,
    output logic        seg_err,
    output logic        an_err
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [6:0]  seg_s1, seg_s2;
    logic [3:0]  an_s1, an_s2;
    logic [10:0] pair_q;
    logic [7:0]  cnt_q;

    logic        same;
    logic        accept;
    logic        hit;
    logic        commit;
    logic [3:0]  slot_oh;
    logic        slot_ok;
    logic        slot_blank;
    logic [3:0]  digit;
    logic        dig_ok;

    logic [3:0]  mask_q, mask_n;
    logic [3:0]  bad_q, bad_n;
    logic [3:0]  shadow_q [4];

    // Synchronizers, previous-sample register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= 7'h7F;
            seg_s2 <= 7'h7F;
            an_s1  <= 4'hF;
            an_s2  <= 4'hF;
            pair_q <= {4'hF, 7'h7F};
            cnt_q  <= 8'd0;
        end else begin
            seg_s1 <= segment7;
            seg_s2 <= seg_s1;
            an_s1  <= an;
            an_s2  <= an_s1;
            pair_q <= {an_s2, seg_s2};
            if (!same)
                cnt_q <= 8'd0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    // Accept on the single cycle the counter steps onto CNT_MAX;
    // saturation then blocks re-acceptance until the pair changes.
    always_comb begin
        same   = ({an_s2, seg_s2} == pair_q);
        accept = same && (cnt_q == CNT_MAX - 8'd1);
    end

    always_comb begin
        slot_oh    = 4'h0;
        slot_ok    = 1'b0;
        slot_blank = 1'b0;
        case (an_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: begin
                slot_oh = ~an_s2;
                slot_ok = 1'b1;
            end
            4'b1111: slot_blank = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        digit  = 4'hF;
        dig_ok = 1'b1;
        case (seg_s2)
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            default:    dig_ok = 1'b0;
        endcase
    end

    // Commit clears the frame state first so a same-cycle
    // acceptance lands in the next frame.
    always_comb begin
        hit    = accept && slot_ok;
        commit = (mask_q == 4'hF);
        mask_n = mask_q;
        bad_n  = bad_q;
        if (commit) begin
            mask_n = 4'h0;
            bad_n  = 4'h0;
        end
        if (hit) begin
            mask_n = mask_n | slot_oh;
            bad_n  = (bad_n & ~slot_oh) | (dig_ok ? 4'h0 : slot_oh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out     <= 16'h0000;
            frame_valid <= 1'b0;
            frame_bad   <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            mask_q      <= 4'h0;
            bad_q       <= 4'h0;
            for (int i = 0; i < 4; i++)
                shadow_q[i] <= 4'h0;
        end else begin
            frame_valid <= commit;
            seg_err     <= hit && !dig_ok;
            an_err      <= accept && !slot_ok && !slot_blank;
            mask_q      <= mask_n;
            bad_q       <= bad_n;
            if (commit) begin
                bcd_out   <= {shadow_q[3], shadow_q[2],
                              shadow_q[1], shadow_q[0]};
                frame_bad <= |bad_q;
            end
            for (int i = 0; i < 4; i++)
                if (hit && slot_oh[i])
                    shadow_q[i] <= digit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYCLES = 4).
// Pulse outputs are counted on the falling edge.
module tb_seg7_scan_decoder;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    localparam logic [3:0] AN_D = 4'b1110;
    localparam logic [3:0] AN_C = 4'b1101;
    localparam logic [3:0] AN_B = 4'b1011;
    localparam logic [3:0] AN_A = 4'b0111;
    localparam logic [3:0] AN_X = 4'b1111;

    logic        clk;
    logic        rst_n;
    logic [6:0]  segment7;
    logic [3:0]  an;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_bad;
    logic        seg_err;
    logic        an_err;

    int n_chk;
    int n_err;
    int n_fv;
    int n_se;
    int n_ae;
    int fv0, se0, ae0;

    seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segment7    (segment7),
        .an          (an),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_bad   (frame_bad),
        .seg_err     (seg_err),
        .an_err      (an_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_fv = 0;
        n_se = 0;
        n_ae = 0;
    end

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (seg_err) n_se++;
        if (an_err) n_ae++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a,
                         input logic [6:0] s,
                         input int n);
        an       = a;
        segment7 = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        fv0 = n_fv;
        se0 = n_se;
        ae0 = n_ae;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_bcd"}, 32'(bcd_out), 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_fb"}, 32'(frame_bad), 32'h0);
        check({tag, "_se"}, 32'(seg_err), 32'h0);
        check({tag, "_ae"}, 32'(an_err), 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        an       = AN_X;
        segment7 = SB;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        snap();
        drive(AN_X, SB, 10);
        check("post_rst_pulses", 32'(n_fv + n_se + n_ae), 32'(fv0 + se0 + ae0));

        // Basic scan D=3 C=0 B=5 A=9
        snap();
        drive(AN_D, S3, 10);
        drive(AN_C, S0, 10);
        drive(AN_B, S5, 10);
        drive(AN_A, S9, 10);
        drive(AN_X, SB, 10);
        check("scan_frames", 32'(n_fv - fv0), 32'd1);
        check("scan_bcd", 32'(bcd_out), 32'h9503);
        check("scan_bad", 32'(frame_bad), 32'h0);
        check("scan_errs", 32'(n_se - se0 + n_ae - ae0), 32'd0);

        // Blank pattern on slot C
        snap();
        drive(AN_D, S1, 10);
        drive(AN_C, SB, 10);
        drive(AN_B, S2, 10);
        drive(AN_A, S4, 10);
        drive(AN_X, SB, 10);
        check("blank_seg_err", 32'(n_se - se0), 32'd1);
        check("blank_frames", 32'(n_fv - fv0), 32'd1);
        check("blank_bcd", 32'(bcd_out), 32'h42F1);
        check("blank_bad", 32'(frame_bad), 32'h1);

        // Illegal an value
        snap();
        drive(4'b1100, S8, 10);
        drive(AN_X, SB, 10);
        check("an_err_cnt", 32'(n_ae - ae0), 32'd1);
        check("an_err_frames", 32'(n_fv - fv0), 32'd0);
        check("hold_bcd", 32'(bcd_out), 32'h42F1);
        check("hold_bad", 32'(frame_bad), 32'h1);

        // Slot D written twice, then C, B, A
        snap();
        drive(AN_D, S1, 10);
        drive(AN_D, S7, 10);
        drive(AN_C, S2, 10);
        drive(AN_B, S8, 10);
        check("redo_partial", 32'(n_fv - fv0), 32'd0);
        drive(AN_A, S6, 10);
        drive(AN_X, SB, 10);
        check("redo_frames", 32'(n_fv - fv0), 32'd1);
        check("redo_bcd", 32'(bcd_out), 32'h6827);
        check("redo_bad", 32'(frame_bad), 32'h0);
        check("redo_errs", 32'(n_se - se0 + n_ae - ae0), 32'd0);

        // Glitching input every 2 cycles must not be accepted
        snap();
        for (int i = 0; i < 10; i++) begin
            drive(AN_D, S3, 2);
            drive(AN_C, 7'b0101010, 2);
        end
        drive(AN_X, SB, 10);
        check("glitch_errs", 32'(n_se - se0 + n_ae - ae0), 32'd0);
        drive(AN_B, S0, 10);
        drive(AN_A, S0, 10);
        drive(AN_X, SB, 10);
        check("glitch_frames", 32'(n_fv - fv0), 32'd0);

        // Third slot captured, then reset mid-frame
        drive(AN_D, S0, 10);
        drive(AN_X, SB, 10);
        check("three_slots", 32'(n_fv - fv0), 32'd0);
        rst_n = 1'b0;
        #2;
        check_outs_zero("midrst");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        snap();
        drive(AN_C, S4, 10);
        drive(AN_X, SB, 10);
        check("after_rst_single", 32'(n_fv - fv0), 32'd0);
        drive(AN_B, S6, 10);
        drive(AN_D, S5, 10);
        drive(AN_A, S8, 10);
        drive(AN_X, SB, 10);
        check("after_rst_frames", 32'(n_fv - fv0), 32'd1);
        check("after_rst_bcd", 32'(bcd_out), 32'h8645);
        check("after_rst_bad", 32'(frame_bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
